twiddle_seq: RTL and testbench
==============================

TWIDDLE_SEQ -- requirements
Module: twiddle_seq

Interface
REQ-001 SHALL have parameter W, default 16: twiddle component width, signed two's complement.
REQ-002 SHALL have parameter LOG2N, default 5: log2 of FFT size N = 2^LOG2N, legal range 3..8.
REQ-003 SHALL have parameter FRAC, default 14: fraction bits, 1.0 = 2^FRAC; FRAC <= W-2 required.
REQ-004 SHALL have port clk, in, 1: clock, all state updates on rising edge.
REQ-005 SHALL have port rst, in, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port cfg_we, in, 1: table write strobe.
REQ-007 SHALL have port cfg_addr, in, LOG2N-1: table index, 0..N/4.
REQ-008 SHALL have port cfg_data, in, W: cos(2*pi*k/N) scaled by 2^FRAC.
REQ-009 SHALL have port start, in, 1: one-cycle request to sequence one FFT stage.
REQ-010 SHALL have port stage, in, 4: stage number s, 0..LOG2N-1, sampled with start.
REQ-011 SHALL have port out_ready, in, 1: consumer accepts the current twiddle.
REQ-012 SHALL have ports out_valid (1), out_re (W), out_im (W), out_idx (LOG2N-1), out_last (1), all out: twiddle stream.
REQ-013 SHALL have ports busy (1), done (1), err (1), all out: status; done and err are single-cycle pulses.

Function
REQ-014 SHALL hold a quarter-wave table of N/4+1 W-bit entries T[0..N/4]; T[k] = cos(2*pi*k/N) in Q(FRAC).
REQ-015 SHALL write T[cfg_addr] <= cfg_data when cfg_we=1, busy=0, cfg_addr <= N/4; otherwise ignore the write.
REQ-016 SHALL have states IDLE and RUN; busy=1 exactly in RUN.
REQ-017 IDLE->RUN on start=1 with stage < LOG2N; counter j cleared to 0; s latched.
REQ-018 start with stage >= LOG2N in IDLE SHALL pulse err for one cycle and stay IDLE; start in RUN SHALL be ignored.
REQ-019 For j = 0..N/2-1, twiddle index SHALL be k = (j mod 2^s) * 2^(LOG2N-1-s).
REQ-020 For k <= N/4: out_re = T[k], out_im = -T[N/4-k].
REQ-021 For k > N/4: out_re = -T[N/2-k], out_im = -T[k-N/4].
REQ-022 Negation SHALL be W-bit two's complement, no saturation; -0 = 0.
REQ-023 out_* SHALL be registered; first out_valid=1 on the cycle after start is accepted (latency 1).
REQ-024 Output register SHALL load the next twiddle when out_valid=0 or out_ready=1; otherwise out_re, out_im, out_idx, out_last hold stable.
REQ-025 out_idx SHALL equal k of the presented twiddle; out_last=1 only with j = N/2-1.
REQ-026 Handshake out_valid=1 and out_ready=1 on the last element SHALL return to IDLE, deassert out_valid next cycle, and pulse done in that cycle.
REQ-027 Exactly N/2 transfers SHALL occur per accepted start, no gaps when out_ready stays 1.
REQ-028 out_ready may change freely while out_valid=0; no twiddle SHALL be dropped or duplicated.

Reset
REQ-029 On rst: state IDLE, j=0, all T entries 0, out_valid=0, out_re=0, out_im=0, out_idx=0, out_last=0, busy=0, done=0, err=0.
REQ-030 rst asserted mid-stage SHALL abort the stage immediately; no done pulse; table contents lost.

Verification (W=16, LOG2N=5, FRAC=14; table loaded T[0..8] = 16384,16069,15137,13623,11585,9102,6270,3196,0)
REQ-031 start, stage=0, out_ready=1 -> 16 consecutive outputs, each re=16384, im=0, idx=0; out_last on 16th; done next cycle.
REQ-032 start, stage=4 -> idx 0..15; idx=1: re=16069, im=-3196; idx=8: re=0, im=-16384; idx=12: re=-11585, im=-11585.
REQ-033 start, stage=2 -> idx sequence 0,4,8,12 repeated 4 times; idx=4: re=11585, im=-11585.
REQ-034 stage=4 with out_ready toggled randomly -> same 16-value sequence as REQ-032, outputs stable while stalled, no loss or repeat.
REQ-035 start with stage=5 -> err pulse, busy stays 0; cfg_we during RUN -> table unchanged, later stage-0 output still 16384.
REQ-036 rst at 7th output of stage 4 -> all outputs 0 next sample, state IDLE, no done; subsequent stage 0 without reload -> re=0, im=0.

Source files
------------

// File: rtl/twiddle_seq_if.sv
// ============================================================================
//  Module      : twiddle_seq_if
//  Description : Configuration, control, twiddle stream and status signals
//                shared between the twiddle sequencer and its user.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface twiddle_seq_if #(
   parameter int W     = 16,
   parameter int LOG2N = 5
);
   logic               cfg_we;
   logic [LOG2N-2:0]   cfg_addr;
   logic [W-1:0]       cfg_data;
   logic               start;
   logic [3:0]         stage;
   logic               out_ready;
   logic               out_valid;
   logic [W-1:0]       out_re;
   logic [W-1:0]       out_im;
   logic [LOG2N-2:0]   out_idx;
   logic               out_last;
   logic               busy;
   logic               done;
   logic               err;

   modport master (
      output cfg_we, cfg_addr, cfg_data, start, stage, out_ready,
      input  out_valid, out_re, out_im, out_idx, out_last, busy, done, err
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data, start, stage, out_ready,
      output out_valid, out_re, out_im, out_idx, out_last, busy, done, err
   );
endinterface

`default_nettype wire

// File: rtl/twiddle_seq.sv
// ============================================================================
//  Module      : twiddle_seq
//  Description : Streams the N/2 twiddle factors of one radix-2 FFT stage,
//                reconstructed from a writable quarter-wave cosine table.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module twiddle_seq #(
   parameter int W     = 16,
   parameter int LOG2N = 5,
   parameter int FRAC  = 14
) (
   input  wire          clk,
   input  wire          rst,
   twiddle_seq_if.slave bus
);
   localparam int N  = 1 << LOG2N;
   localparam int IW = LOG2N - 1;           // width of table / twiddle index
   localparam int JW = LOG2N;               // counter width, holds up to N/2

   localparam logic [JW-1:0] C_QJ    = JW'(N / 4);
   localparam logic [JW-1:0] C_HJ    = JW'(N / 2);
   localparam logic [JW-1:0] C_LASTJ = JW'(N / 2 - 1);
   localparam logic [IW-1:0] C_QA    = IW'(N / 4);
   localparam logic [3:0]    C_STG   = 4'(LOG2N);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   if (FRAC > W - 2 || LOG2N < 3 || LOG2N > 8) begin : g_bad_param
      $error("twiddle_seq: illegal parameter combination");
   end

   logic [W-1:0]  tbl_q [0:N/4];
   logic [0:0]    state_q, state_d;
   logic [JW-1:0] j_q, j_d;                 // index of the next twiddle to issue
   logic [3:0]    s_q, s_d;
   logic          valid_q, valid_d;
   logic [W-1:0]  re_q, re_d, im_q, im_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          last_q, last_d;
   logic          done_q, done_d, err_q, err_d;

   logic [JW-1:0] w_jsel, w_mask, w_kw, w_ia, w_ib;
   logic          w_lower, w_issue;
   logic [W-1:0]  w_ta, w_tb, w_re, w_im;

   // Map the issue counter to its twiddle index and unfold the quarter wave.
   always_comb begin
      w_jsel  = (state_q == S_RUN) ? j_q : '0;
      w_mask  = JW'((32'd1 << s_q) - 32'd1);
      w_kw    = (w_jsel & w_mask) << (LOG2N - 1 - int'(s_q));
      w_lower = (w_kw <= C_QJ);
      w_ia    = w_lower ? w_kw : C_HJ - w_kw;
      w_ib    = w_lower ? C_QJ - w_kw : w_kw - C_QJ;
      w_ta    = tbl_q[w_ia[IW-1:0]];
      w_tb    = tbl_q[w_ib[IW-1:0]];
      w_re    = w_lower ? w_ta : -w_ta;
      w_im    = -w_tb;
   end

   // Sequencer next state: accept a stage, refill the output on each accept.
   always_comb begin
      state_d = state_q;
      j_d     = j_q;
      s_d     = s_q;
      valid_d = valid_q;
      re_d    = re_q;
      im_d    = im_q;
      idx_d   = idx_q;
      last_d  = last_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      w_issue = 1'b0;
      if (state_q == S_IDLE) begin
         if (bus.start) begin
            if (bus.stage < C_STG) begin
               state_d = S_RUN;
               s_d     = bus.stage;
               w_issue = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end
      end else begin
         if (valid_q && bus.out_ready && last_q) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
            j_d     = '0;
         end else if ((!valid_q || bus.out_ready) && (j_q < C_HJ)) begin
            w_issue = 1'b1;
         end
      end
      if (w_issue) begin
         valid_d = 1'b1;
         re_d    = w_re;
         im_d    = w_im;
         idx_d   = w_kw[IW-1:0];
         last_d  = (w_jsel == C_LASTJ);
         j_d     = w_jsel + 1'b1;
      end
   end

   // Sequencer and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         j_q     <= '0;
         s_q     <= '0;
         valid_q <= 1'b0;
         re_q    <= '0;
         im_q    <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         s_q     <= s_d;
         valid_q <= valid_d;
         re_q    <= re_d;
         im_q    <= im_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Quarter-wave table; writable only while idle and within range.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= N / 4; i++) begin
            tbl_q[i] <= '0;
         end
      end else if (bus.cfg_we && (state_q == S_IDLE) && (bus.cfg_addr <= C_QA)) begin
         tbl_q[bus.cfg_addr] <= bus.cfg_data;
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.out_re    = re_q;
   assign bus.out_im    = im_q;
   assign bus.out_idx   = idx_q;
   assign bus.out_last  = last_q;
   assign bus.busy      = (state_q == S_RUN);
   assign bus.done      = done_q;
   assign bus.err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_twiddle_seq.sv
// ============================================================================
//  Module      : tb_twiddle_seq
//  Description : Self-checking bench for twiddle_seq (W=16, LOG2N=5, FRAC=14).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_twiddle_seq;
   localparam int W     = 16;
   localparam int LOG2N = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   twiddle_seq_if #(.W(W), .LOG2N(LOG2N)) bus ();

   twiddle_seq #(.W(W), .LOG2N(LOG2N), .FRAC(14)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0;
   int fails = 0;

   logic signed [15:0] tab     [0:8];
   logic signed [15:0] exp_re  [0:15];
   logic signed [15:0] exp_im  [0:15];
   logic        [3:0]  exp_idx [0:15];
   logic signed [15:0] cap_re  [0:15];
   logic signed [15:0] cap_im  [0:15];
   logic        [3:0]  cap_idx [0:15];

   // Reference: w^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) rebuilt from the quarter wave.
   task automatic build_exp(input int s);
      for (int j = 0; j < 16; j++) begin
         int k;
         k = (j % (1 << s)) * (1 << (4 - s));
         exp_idx[j] = 4'(k);
         if (k <= 8) begin
            exp_re[j] = tab[k];
            exp_im[j] = -tab[8 - k];
         end else begin
            exp_re[j] = -tab[16 - k];
            exp_im[j] = -tab[k - 8];
         end
      end
   endtask

   task automatic cfg_write(input int addr, input logic [15:0] data);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 4'(addr);
      bus.cfg_data = data;
      @(negedge clk);
      bus.cfg_we = 1'b0;
      if (addr <= 8) tab[addr] = data;
   endtask

   // Runs one stage; rnd randomizes out_ready, poke writes the table and
   // re-issues start while the stage is running.
   task automatic run_stage(input int s, input bit rnd, input bit poke);
      int n = 0;
      int cyc = 0;
      bit stalled = 0;
      bit rdy;
      logic [15:0] h_re, h_im;
      logic [3:0]  h_idx;
      logic        h_last;
      build_exp(s);
      bus.start = 1'b1;
      bus.stage = 4'(s);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      while (n < 16 && cyc < 300) begin
         tests++;
         if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL run_valid s=%0d n=%0d: valid=%b busy=%b, expected 1 1", s, n, bus.out_valid, bus.busy);
         end
         if (stalled) begin
            tests++;
            if ({bus.out_re, bus.out_im, bus.out_idx, bus.out_last} !== {h_re, h_im, h_idx, h_last}) begin
               fails++;
               $display("FAIL stall_hold s=%0d n=%0d: got re=%0d im=%0d idx=%0d, held re=%0d im=%0d idx=%0d",
                        s, n, $signed(bus.out_re), $signed(bus.out_im), bus.out_idx,
                        $signed(h_re), $signed(h_im), h_idx);
            end
         end
         if (poke && cyc == 0) begin
            bus.cfg_we = 1'b1; bus.cfg_addr = 4'd0; bus.cfg_data = 16'd1234;
            bus.start = 1'b1;  bus.stage = 4'd0;
         end else begin
            bus.cfg_we = 1'b0;
            bus.start  = 1'b0;
         end
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.out_ready = rdy;
         if (rdy) begin
            tests++;
            if (bus.out_re !== exp_re[n] || bus.out_im !== exp_im[n] ||
                bus.out_idx !== exp_idx[n] || bus.out_last !== (n == 15)) begin
               fails++;
               $display("FAIL twiddle s=%0d n=%0d: got re=%0d im=%0d idx=%0d last=%b, expected re=%0d im=%0d idx=%0d last=%b",
                        s, n, $signed(bus.out_re), $signed(bus.out_im), bus.out_idx, bus.out_last,
                        exp_re[n], exp_im[n], exp_idx[n], (n == 15));
            end
            cap_re[n]  = bus.out_re;
            cap_im[n]  = bus.out_im;
            cap_idx[n] = bus.out_idx;
            n++;
            stalled = 0;
         end else begin
            stalled = 1;
            h_re = bus.out_re; h_im = bus.out_im; h_idx = bus.out_idx; h_last = bus.out_last;
         end
         @(negedge clk);
         cyc++;
      end
      bus.cfg_we = 1'b0;
      bus.start  = 1'b0;
      tests++;
      if (n != 16) begin
         fails++;
         $display("FAIL stage_timeout s=%0d: %0d transfers, expected 16", s, n);
      end
      tests++;
      if (bus.out_valid !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL stage_end s=%0d: valid=%b done=%b busy=%b, expected 0 1 0", s, bus.out_valid, bus.done, bus.busy);
      end
      @(negedge clk);
      tests++;
      if (bus.done !== 1'b0) begin
         fails++;
         $display("FAIL done_pulse s=%0d: done=%b, expected 0", s, bus.done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_data = 0;
      bus.start = 0; bus.stage = 0; bus.out_ready = 0;
      for (int i = 0; i <= 8; i++) tab[i] = '0;
      repeat (3) @(negedge clk);
      tests++;
      if ({bus.out_valid, bus.out_re, bus.out_im, bus.out_idx, bus.out_last, bus.busy, bus.done, bus.err} !== '0) begin
         fails++;
         $display("FAIL reset_state: valid=%b re=%0d im=%0d idx=%0d last=%b busy=%b done=%b err=%b, expected all 0",
                  bus.out_valid, bus.out_re, bus.out_im, bus.out_idx, bus.out_last, bus.busy, bus.done, bus.err);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_load_table();
      logic [15:0] vals [0:8];
      vals = '{16'd16384, 16'd16069, 16'd15137, 16'd13623, 16'd11585, 16'd9102, 16'd6270, 16'd3196, 16'd0};
      for (int i = 0; i <= 8; i++) cfg_write(i, vals[i]);
      for (int i = 9; i < 16; i++) cfg_write(i, 16'($urandom));
   endtask

   task automatic test_stage4();
      run_stage(4, 0, 0);
      tests++;
      if (cap_re[1] !== 16'sd16069 || cap_im[1] !== -16'sd3196 || cap_re[8] !== 16'sd0 ||
          cap_im[8] !== -16'sd16384 || cap_re[12] !== -16'sd11585 || cap_im[12] !== -16'sd11585) begin
         fails++;
         $display("FAIL stage4_points: idx1=(%0d,%0d) idx8=(%0d,%0d) idx12=(%0d,%0d), expected (16069,-3196) (0,-16384) (-11585,-11585)",
                  cap_re[1], cap_im[1], cap_re[8], cap_im[8], cap_re[12], cap_im[12]);
      end
   endtask

   task automatic test_stage2();
      run_stage(2, 0, 0);
      tests++;
      if (cap_idx[5] !== 4'd4 || cap_idx[14] !== 4'd8 || cap_re[1] !== 16'sd11585 || cap_im[1] !== -16'sd11585) begin
         fails++;
         $display("FAIL stage2_points: idx5=%0d idx14=%0d re=%0d im=%0d, expected 4 8 11585 -11585",
                  cap_idx[5], cap_idx[14], cap_re[1], cap_im[1]);
      end
   endtask

   task automatic test_backpressure();
      run_stage(4, 1, 0);
      tests++;
      if (cap_re[12] !== -16'sd11585 || cap_idx[15] !== 4'd15) begin
         fails++;
         $display("FAIL stall_points: re12=%0d idx15=%0d, expected -11585 15", cap_re[12], cap_idx[15]);
      end
   endtask

   task automatic test_err();
      bus.start = 1'b1;
      bus.stage = 4'($urandom_range(5, 15));
      @(negedge clk);
      bus.start = 1'b0;
      tests++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL err_pulse: err=%b busy=%b valid=%b, expected 1 0 0", bus.err, bus.busy, bus.out_valid);
      end
      @(negedge clk);
      tests++;
      if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL err_clear: err=%b busy=%b, expected 0 0", bus.err, bus.busy);
      end
   endtask

   task automatic test_cfg_during_run();
      run_stage(0, 0, 1);
      run_stage(0, 0, 0);
      tests++;
      if (cap_re[0] !== 16'sd16384 || cap_im[15] !== 16'sd0) begin
         fails++;
         $display("FAIL cfg_locked: re=%0d im=%0d, expected 16384 0", cap_re[0], cap_im[15]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i <= 8; i++) cfg_write(i, 16'($urandom));
      cfg_write(0, 16'h8000);
      for (int r = 0; r < 4; r++) run_stage($urandom_range(0, 4), 1, 0);
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b1;
      bus.start = 1'b1;
      bus.stage = 4'd4;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (6) @(negedge clk);
      tests++;
      if (bus.out_idx !== 4'd6 || bus.out_valid !== 1'b1) begin
         fails++;
         $display("FAIL seventh_out: idx=%0d valid=%b, expected 6 1", bus.out_idx, bus.out_valid);
      end
      rst = 1'b1;
      #1;
      tests++;
      if ({bus.out_valid, bus.out_re, bus.out_im, bus.out_idx, bus.out_last, bus.busy, bus.done, bus.err} !== '0) begin
         fails++;
         $display("FAIL mid_reset: valid=%b re=%0d im=%0d idx=%0d busy=%b done=%b, expected all 0",
                  bus.out_valid, bus.out_re, bus.out_im, bus.out_idx, bus.busy, bus.done);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i <= 8; i++) tab[i] = '0;
      @(negedge clk);
      tests++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL post_reset: done=%b busy=%b valid=%b, expected 0 0 0", bus.done, bus.busy, bus.out_valid);
      end
      run_stage(0, 0, 0);
      tests++;
      if (cap_re[0] !== 16'sd0 || cap_im[0] !== 16'sd0) begin
         fails++;
         $display("FAIL table_cleared: re=%0d im=%0d, expected 0 0", cap_re[0], cap_im[0]);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load_table();
      run_stage(0, 0, 0);
      test_stage4();
      test_stage2();
      test_backpressure();
      test_err();
      test_cfg_during_run();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
